// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one read or write per request, SETUP/ACCESS/HOLD strobing
// with a programmable ACCESS length, bidirectional data bus driven only for writes.
module sram_ctrl #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int WAIT_CNT = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_wr_n,
   output logic              sram_oe_n,
   inout  wire  [DATA_W-1:0] sram_data
);

   // state  | meaning
   // IDLE   | ready for a request; address and read data held
   // SETUP  | address presented, strobes inactive (1 cycle)
   // ACCESS | wr_n or oe_n asserted for WAIT_CNT+1 cycles
   // HOLD   | strobes released, write data still driven / read data valid (1 cycle)
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_CNT);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              drive_en;
   logic              accept;
   logic              access_done;

   assign accept      = (state_q == IDLE) && req_valid;
   assign access_done = (state_q == ACCESS) && (cnt_q == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         // oe_n is still low on this edge, so the SRAM is still driving the bus
         if (access_done && !wr_q) begin
            rd_data_q <= sram_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (req_valid) state_d = SETUP;
         end
         SETUP: begin
            cnt_d   = 8'd0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = 8'd0;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign sram_wr_n = !((state_q == ACCESS) && wr_q);
   assign sram_oe_n = !((state_q == ACCESS) && !wr_q);
   assign rd_valid  = (state_q == HOLD) && !wr_q;
   assign drive_en  = wr_q && (state_q != IDLE);
   assign sram_addr = addr_q;
   assign rd_data   = rd_data_q;
   assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (WAIT_CNT 7 and 0) with SRAM models, checked
// cycle by cycle against a timing/memory reference built from the access rules.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_wr    [2];
   logic [14:0] req_addr  [2];
   logic [7:0]  req_wdata [2];
   logic        req_ready [2];
   logic        rd_valid  [2];
   logic [7:0]  rd_data   [2];
   logic [14:0] sram_addr [2];
   logic        sram_wr_n [2];
   logic        sram_oe_n [2];
   wire  [7:0]  bus0;
   wire  [7:0]  bus1;

   bit   [7:0]  mem0 [32768];
   bit   [7:0]  mem1 [32768];
   bit   [7:0]  ref_mem [2][32768];
   logic [7:0]  exp_rd    [2];
   logic [14:0] last_addr [2];
   logic        bd_en;
   logic [14:0] bd_addr;
   logic [7:0]  bd_data;

   int n_vec = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   sram_ctrl #(.ADDR_W(15), .DATA_W(8), .WAIT_CNT(7)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
      .sram_addr(sram_addr[0]), .sram_wr_n(sram_wr_n[0]), .sram_oe_n(sram_oe_n[0]),
      .sram_data(bus0)
   );

   sram_ctrl #(.ADDR_W(15), .DATA_W(8), .WAIT_CNT(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
      .sram_addr(sram_addr[1]), .sram_wr_n(sram_wr_n[1]), .sram_oe_n(sram_oe_n[1]),
      .sram_data(bus1)
   );

   // SRAM models: drive on oe_n low, store on every edge with wr_n low
   assign bus0 = !sram_oe_n[0] ? mem0[sram_addr[0]] : 8'bz;
   assign bus1 = !sram_oe_n[1] ? mem1[sram_addr[1]] : 8'bz;

   always @(posedge clk) begin
      if (bd_en) mem0[bd_addr] <= bd_data;
      if (!sram_wr_n[0]) mem0[sram_addr[0]] <= bus0;
      if (!sram_wr_n[1]) mem1[sram_addr[1]] <= bus1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] bus(input int d);
      return (d == 0) ? bus0 : bus1;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int d = 0; d < 2; d++)
            chk("strobe_excl", {31'd0, (!sram_wr_n[d] && !sram_oe_n[d])}, 32'd0);
      end
   end

   task automatic wait_ready(input int d, output int waited);
      waited = 0;
      @(negedge clk);
      while (!req_ready[d] && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      chk("ready_idle", {31'd0, req_ready[d]}, 32'd1);
   endtask

   // one full transaction; busy cycles are filled with random request junk
   task automatic txn(input int d, input bit wr, input logic [14:0] addr,
                      input logic [7:0] wd, output int waited);
      int w;
      w = (d == 0) ? 7 : 0;
      wait_ready(d, waited);
      chk("idle_addr_hold", {17'd0, sram_addr[d]}, {17'd0, last_addr[d]});
      chk("idle_rd_hold", {24'd0, rd_data[d]}, {24'd0, exp_rd[d]});
      req_valid[d] = 1'b1;
      req_wr[d]    = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      if (wr) ref_mem[d][addr] = wd;
      for (int k = 1; k <= w + 3; k++) begin
         @(negedge clk);
         chk("busy_ready", {31'd0, req_ready[d]}, 32'd0);
         chk("wr_n", {31'd0, sram_wr_n[d]}, {31'd0, !(wr && k >= 2 && k <= w + 2)});
         chk("oe_n", {31'd0, sram_oe_n[d]}, {31'd0, !(!wr && k >= 2 && k <= w + 2)});
         chk("sram_addr", {17'd0, sram_addr[d]}, {17'd0, addr});
         chk("rd_valid", {31'd0, rd_valid[d]}, {31'd0, (!wr && k == w + 3)});
         if (wr) chk("wr_bus", {24'd0, bus(d)}, {24'd0, wd});
         if (k == w + 3) begin
            if (!wr) exp_rd[d] = ref_mem[d][addr];
            chk("rd_data", {24'd0, rd_data[d]}, {24'd0, exp_rd[d]});
         end
         req_valid[d] = (k < w + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_wr[d]    = 1'($urandom_range(0, 1));
         req_addr[d]  = 15'($urandom);
         req_wdata[d] = 8'($urandom);
      end
      last_addr[d] = addr;
   endtask

   initial begin
      int          waited;
      int          d;
      bit          wr;
      logic [14:0] pool [8];
      logic [14:0] a;

      rst_n = 1'b0;
      bd_en = 1'b0; bd_addr = '0; bd_data = '0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
         exp_rd[i] = '0; last_addr[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", {31'd0, req_ready[i]}, 32'd1);
         chk("rst_rd_valid", {31'd0, rd_valid[i]}, 32'd0);
         chk("rst_rd_data", {24'd0, rd_data[i]}, 32'd0);
         chk("rst_addr", {17'd0, sram_addr[i]}, 32'd0);
         chk("rst_wr_n", {31'd0, sram_wr_n[i]}, 32'd1);
         chk("rst_oe_n", {31'd0, sram_oe_n[i]}, 32'd1);
      end
      rst_n = 1'b1;

      txn(0, 1'b1, 15'h0005, 8'hA5, waited);

      @(negedge clk);
      bd_en = 1'b1; bd_addr = 15'h0005; bd_data = 8'h3C;
      ref_mem[0][15'h0005] = 8'h3C;
      @(negedge clk);
      bd_en = 1'b0;
      txn(0, 1'b0, 15'h0005, 8'h00, waited);
      chk("read_3c", {24'd0, rd_data[0]}, 32'h3C);

      for (int i = 0; i < 4; i++) begin
         txn(0, (i % 2) == 0, 15'h7FFF, 8'h5A, waited);
         if (i > 0) chk("b2b_gap", waited, 32'd0);
      end
      chk("b2b_read", {24'd0, rd_data[0]}, 32'h5A);

      @(negedge clk);
      chk("no_extra_txn", {31'd0, req_ready[0]}, 32'd1);
      @(negedge clk);
      chk("no_extra_txn", {31'd0, req_ready[0]}, 32'd1);

      wait_ready(0, waited);
      req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 15'h0123; req_wdata[0] = 8'h77;
      ref_mem[0][15'h0123] = 8'h77;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         req_valid[0] = 1'b0;
      end
      chk("pre_rst_wr_n", {31'd0, sram_wr_n[0]}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_n", {31'd0, sram_wr_n[0]}, 32'd1);
      chk("mid_rst_oe_n", {31'd0, sram_oe_n[0]}, 32'd1);
      chk("mid_rst_ready", {31'd0, req_ready[0]}, 32'd1);
      chk("mid_rst_addr", {17'd0, sram_addr[0]}, 32'd0);
      chk("mid_rst_rd_data", {24'd0, rd_data[0]}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         exp_rd[i] = '0; last_addr[i] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      txn(0, 1'b0, 15'h0123, 8'h00, waited);
      chk("post_rst_read", {24'd0, rd_data[0]}, 32'h77);

      txn(1, 1'b1, 15'h0010, 8'hC3, waited);
      txn(1, 1'b0, 15'h0010, 8'h00, waited);
      chk("w0_read", {24'd0, rd_data[1]}, 32'hC3);

      for (int i = 0; i < 8; i++) pool[i] = 15'($urandom);
      for (int i = 0; i < 40; i++) begin
         d  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = pool[$urandom_range(0, 7)];
         repeat ($urandom_range(0, 2)) @(negedge clk);
         txn(d, wr, a, 8'($urandom), waited);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
